detect_collector: RTL and testbench

Consumer side of the threshold-detector handshake. Accepts `valid`/`detect_time` events from N_CH threshold channels (one per microphone) and returns the one-cycle `ack` each channel needs to re-arm. When every channel has reported within a bounded window, it publishes channel 0's timestamp plus per-channel signed arrival differences to the localisation stage over a valid/ack handshake. It sits between the per-channel threshold detectors and the direction-estimation logic.

---
 rtl/detect_collector_if.sv | 25 ++
 rtl/detect_collector.sv | 116 +++++++++++
 tb/tb_detect_collector.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/detect_collector_if.sv
// Handshake bundle between the threshold detectors, the collector and the
// localisation stage. The master drives events and out_ack; the slave is the collector.
interface detect_collector_if #(
    parameter int N_CH = 3,
    parameter int TW   = 32
);
    logic [N_CH-1:0]    ch_valid;
    logic [N_CH*TW-1:0] ch_time;
    logic [N_CH-1:0]    ch_ack;
    logic               out_valid;
    logic               out_ack;
    logic [TW-1:0]      ref_time;
    logic [N_CH*TW-1:0] delta;
    logic               timeout_err;

    modport master (
        output ch_valid, ch_time, out_ack,
        input  ch_ack, out_valid, ref_time, delta, timeout_err
    );

    modport slave (
        input  ch_valid, ch_time, out_ack,
        output ch_ack, out_valid, ref_time, delta, timeout_err
    );
endinterface

// File: rtl/detect_collector.sv
// Gathers one timestamp per threshold channel within a bounded window and
// publishes channel 0's time plus signed per-channel arrival differences.
//
// state   | meaning
// IDLE    | nothing captured, waiting for the first detection
// COLLECT | some channels captured, window timer running
// CALC    | every channel captured, computing ref_time and delta
// HOLD    | result presented, waiting for out_ack
module detect_collector #(
    parameter int N_CH    = 3,
    parameter int TW      = 32,
    parameter int TIMEOUT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    detect_collector_if.slave bus
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, COLLECT, CALC, HOLD} state_t;

    state_t          state, state_nxt;
    logic [N_CH-1:0] cap, cap_nxt, take;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            tmo_nxt;
    logic [TW-1:0]   t_lat [N_CH];

    logic [N_CH-1:0]    ack_q;
    logic               out_valid_q;
    logic               tmo_q;
    logic [TW-1:0]      ref_q;
    logic [N_CH*TW-1:0] delta_q;

    assign bus.ch_ack      = ack_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.timeout_err = tmo_q;
    assign bus.ref_time    = ref_q;
    assign bus.delta       = delta_q;

    // Window timer counts down from TIMEOUT-1; reaching zero incomplete ends the round.
    always_comb begin
        take      = '0;
        cap_nxt   = cap;
        cnt_nxt   = cnt;
        state_nxt = state;
        tmo_nxt   = 1'b0;
        if (state == IDLE || state == COLLECT) begin
            take    = bus.ch_valid & ~cap;
            cap_nxt = cap | take;
        end
        case (state)
            IDLE: begin
                if (|take) begin
                    cnt_nxt   = CW'(TIMEOUT - 1);
                    state_nxt = (&cap_nxt) ? CALC : COLLECT;
                end
            end
            COLLECT: begin
                if (&cap_nxt) begin
                    state_nxt = CALC;
                end else if (cnt == '0) begin
                    tmo_nxt   = 1'b1;
                    cap_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            CALC: state_nxt = HOLD;
            HOLD: begin
                if (out_valid_q && bus.out_ack) begin
                    cap_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cap   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cap   <= cap_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q       <= '0;
            tmo_q       <= 1'b0;
            out_valid_q <= 1'b0;
            ref_q       <= '0;
            delta_q     <= '0;
            for (int i = 0; i < N_CH; i++) t_lat[i] <= '0;
        end else begin
            ack_q       <= take;
            tmo_q       <= tmo_nxt;
            // Rises one cycle after HOLD is entered; an ack before then is ignored.
            out_valid_q <= (state == HOLD) && !(out_valid_q && bus.out_ack);
            for (int i = 0; i < N_CH; i++) begin
                if (take[i]) t_lat[i] <= bus.ch_time[i*TW +: TW];
            end
            if (state == CALC) begin
                ref_q <= t_lat[0];
                for (int i = 0; i < N_CH; i++) begin
                    delta_q[i*TW +: TW] <= t_lat[i] - t_lat[0];
                end
            end
        end
    end
endmodule

// File: tb/tb_detect_collector.sv
// Directed bench for detect_collector: a cycle-numbered round model checked
// every cycle, plus literal expectations for each scenario.
module tb_detect_collector;
    localparam int N  = 3;
    localparam int TW = 32;
    localparam int TO = 10;

    logic clk;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   stepn = 0;

    detect_collector_if #(.N_CH(N), .TW(TW)) bus ();

    detect_collector #(.N_CH(N), .TW(TW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: a round is described by edge numbers (first capture, completion)
    bit              open, finished;
    bit [N-1:0]      got;
    logic [TW-1:0]   tm [N];
    int              mcyc = 0, first_cyc = 0, done_cyc = 0;
    logic [N-1:0]    exp_ack;
    logic            exp_tmo, exp_ov;
    logic [TW-1:0]   exp_ref;
    logic [TW-1:0]   exp_delta [N];

    task automatic model_step();
        if (!rst) begin
            open = 0; finished = 0; got = '0;
            exp_ack = '0; exp_tmo = 0; exp_ov = 0; exp_ref = '0;
            for (int i = 0; i < N; i++) exp_delta[i] = '0;
        end else begin
            mcyc++;
            exp_ack = '0;
            exp_tmo = 0;
            if (!finished) begin
                for (int i = 0; i < N; i++) begin
                    if (bus.ch_valid[i] && !got[i]) begin
                        got[i] = 1'b1;
                        tm[i] = bus.ch_time[i*TW +: TW];
                        exp_ack[i] = 1'b1;
                    end
                end
                if (|exp_ack && !open) begin
                    open = 1; first_cyc = mcyc;
                end
                if (&got) begin
                    finished = 1; done_cyc = mcyc; open = 0;
                end else if (open && mcyc == first_cyc + TO) begin
                    exp_tmo = 1; open = 0; got = '0;
                end
            end else begin
                if (mcyc == done_cyc + 1) begin
                    exp_ref = tm[0];
                    for (int i = 0; i < N; i++) exp_delta[i] = tm[i] - tm[0];
                end
                if (exp_ov && bus.out_ack) begin
                    finished = 0; got = '0; exp_ov = 0;
                end else if (mcyc >= done_cyc + 2) begin
                    exp_ov = 1;
                end
            end
        end
    endtask

    initial begin
        open = 0; finished = 0; got = '0;
        exp_ack = '0; exp_tmo = 0; exp_ov = 0; exp_ref = '0;
        for (int i = 0; i < N; i++) begin
            exp_delta[i] = '0;
            tm[i] = '0;
        end
        forever begin
            @(posedge clk or negedge rst);
            model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("ack", 64'(bus.ch_ack), 64'(exp_ack));
            chk("timeout_err", 64'(bus.timeout_err), 64'(exp_tmo));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            chk("ref_time", 64'(bus.ref_time), 64'(exp_ref));
            for (int i = 0; i < N; i++)
                chk($sformatf("delta%0d", i), 64'(bus.delta[i*TW +: TW]), 64'(exp_delta[i]));
        end
    end

    // One clock; acked detectors drop their valid just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        stepn++;
        for (int i = 0; i < N; i++)
            if (bus.ch_ack[i]) bus.ch_valid[i] = 1'b0;
    endtask

    task automatic raise(input int ch, input logic [TW-1:0] t);
        bus.ch_valid[ch] = 1'b1;
        bus.ch_time[ch*TW +: TW] = t;
    endtask

    task automatic wait_ov(input string name);
        for (int i = 0; i < 20 && !bus.out_valid; i++) step();
        chk(name, 64'(bus.out_valid), 64'd1);
    endtask

    task automatic take_result();
        bus.out_ack = 1'b1;
        step();
        bus.out_ack = 1'b0;
    endtask

    task automatic lit_delta(input string name, input logic [TW-1:0] r,
                             input logic [TW-1:0] d1, input logic [TW-1:0] d2);
        chk({name, "_ref"}, 64'(bus.ref_time), 64'(r));
        chk({name, "_d0"}, 64'(bus.delta[0 +: TW]), 64'd0);
        chk({name, "_d1"}, 64'(bus.delta[TW +: TW]), 64'(d1));
        chk({name, "_d2"}, 64'(bus.delta[2*TW +: TW]), 64'(d2));
    endtask

    initial begin
        int s0, acks_seen;
        bit seen;
        rst = 1'b0;
        bus.ch_valid = '0;
        bus.ch_time = '0;
        bus.out_ack = 1'b0;
        step(); step();
        chk("reset_outs", {bus.ch_ack, bus.out_valid, bus.timeout_err}, 64'd0);
        chk("reset_ref", 64'(bus.ref_time), 64'd0);
        rst = 1'b1;
        step();

        // Basic round on separate edges
        raise(0, 100); step();
        chk("basic_ack0", 64'(bus.ch_ack), 64'b001);
        raise(1, 105); step();
        chk("basic_ack1", 64'(bus.ch_ack), 64'b010);
        raise(2, 97);
        wait_ov("basic_ov");
        lit_delta("basic", 100, 32'd5, 32'hFFFF_FFFD);
        take_result();
        step();

        // Simultaneous arrival
        raise(0, 500); raise(1, 500); raise(2, 501);
        step();
        chk("simul_acks", 64'(bus.ch_ack), 64'b111);
        step();
        chk("simul_ov_k1", 64'(bus.out_valid), 64'd0);
        step();
        chk("simul_ov_k2", 64'(bus.out_valid), 64'd1);
        lit_delta("simul", 500, 32'd0, 32'd1);
        take_result();

        // Wrap-around of the timestamp
        raise(0, 32'hFFFF_FFFE); raise(1, 32'h0000_0003); step();
        raise(2, 32'hFFFF_FFF0);
        wait_ov("wrap_ov");
        lit_delta("wrap", 32'hFFFF_FFFE, 32'd5, 32'hFFFF_FFF2);
        take_result();
        step();

        // Timeout with channel 2 silent
        raise(0, 1); raise(1, 2);
        step();
        s0 = stepn;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (bus.timeout_err) seen = 1;
        end
        chk("tmo_seen", 64'(seen), 64'd1);
        chk("tmo_latency", 64'(stepn - s0), 64'(TO));
        step();
        chk("tmo_pulse_width", 64'(bus.timeout_err), 64'd0);
        raise(0, 10); step(); raise(1, 20); step(); raise(2, 30);
        wait_ov("after_tmo_ov");
        lit_delta("after_tmo", 10, 32'd10, 32'd20);

        // Back-pressure while channel 1 has a new pending event
        raise(1, 777);
        acks_seen = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.ch_ack != '0) acks_seen++;
        end
        chk("bp_no_ack", 64'(acks_seen), 64'd0);
        lit_delta("bp_stable", 10, 32'd10, 32'd20);
        take_result();
        chk("bp_ack_edge1", 64'(bus.ch_ack), 64'd0);
        step();
        chk("bp_ack_edge2", 64'(bus.ch_ack), 64'b010);
        raise(0, 770); raise(2, 780);
        wait_ov("bp_round_ov");
        lit_delta("bp_round", 770, 32'd7, 32'd10);
        take_result();
        step();

        // Reset mid-round
        raise(0, 5); step();
        chk("mid_ack", 64'(bus.ch_ack), 64'b001);
        rst = 1'b0;
        #1;
        chk("mid_rst_outs", {bus.ch_ack, bus.out_valid, bus.timeout_err}, 64'd0);
        chk("mid_rst_ref", 64'(bus.ref_time), 64'd0);
        chk("mid_rst_delta", 64'(bus.delta[TW +: TW]), 64'd0);
        bus.ch_valid = '0;
        step();
        rst = 1'b1;
        step();
        raise(0, 40); step(); raise(1, 41); step(); raise(2, 42);
        wait_ov("post_rst_ov");
        lit_delta("post_rst", 40, 32'd1, 32'd2);
        take_result();
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
